// File: rtl/tot_trigger_multi.sv
// Multi-channel time-over-threshold trigger: per-channel compare, multiplicity, sliding-window
// occupancy with holdoff. Optional peak-occupancy tracking when TOT_PEAK_OCC_EN is defined.
module tot_trigger_multi #(
  parameter int unsigned ADC_WIDTH = 12,
  parameter int unsigned NCHAN     = 3,
  parameter int unsigned WIDTH     = 122,
  parameter int unsigned DECIM     = 3,
  parameter int unsigned HOLD_W    = 8,
  localparam int unsigned MULT_W   = $clog2(NCHAN + 1),
  localparam int unsigned OCC_W    = $clog2(WIDTH + 1)
) (
  input  logic                       CLK120,
  input  logic                       RESET_N,
  input  logic                       SYNC,
  input  logic [NCHAN*ADC_WIDTH-1:0] ADC,
  input  logic [NCHAN*ADC_WIDTH-1:0] THRES,
  input  logic [NCHAN-1:0]           TRIG_ENABLE,
  input  logic [MULT_W-1:0]          MULTIPLICITY,
  input  logic [OCC_W-1:0]           OCCUPANCY,
  input  logic [HOLD_W-1:0]          HOLDOFF,
`ifdef TOT_PEAK_OCC_EN
  input  logic                       PEAK_CLR,
  output logic [OCC_W-1:0]           PEAK_OCC,
`endif
  output logic                       TRIG,
  output logic [31:0]                TRIG_COUNT,
  output logic [OCC_W-1:0]           OCC_NOW,
  output logic                       DEBUG
);

  localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PH_W-1:0]            phase_q, phase_d;
  logic                       tick;
  logic [NCHAN*ADC_WIDTH-1:0] adc_q, thres_q;
  logic [NCHAN-1:0]           pmt_q, pmt_d;
  logic [MULT_W-1:0]          sum_q, sum_d;
  logic                       sb_q, sb_d;
  logic                       debug_q;
  logic [WIDTH-1:0]           window_q, window_d;
  logic [OCC_W-1:0]           occ_q, occ_d;
  logic [HOLD_W-1:0]          hold_q, hold_d;
  logic                       trig_q, trig_d;
  logic [31:0]                count_q, count_d;
  logic                       fire;

  // SYNC forces phase 0 so the following clock is a tick.
  always_comb begin
    if (SYNC) begin
      phase_d = '0;
    end else if (phase_q == PH_W'(DECIM - 1)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end
  end

  assign tick = (phase_q == '0);

  always_comb begin
    pmt_d = '0;
    for (int i = 0; i < NCHAN; i++) begin
      pmt_d[i] = (adc_q[i*ADC_WIDTH +: ADC_WIDTH] > thres_q[i*ADC_WIDTH +: ADC_WIDTH]) &&
                 TRIG_ENABLE[i];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NCHAN; i++) begin
      sum_d = sum_d + MULT_W'(pmt_q[i]);
    end
  end

  assign sb_d = (sum_q >= MULTIPLICITY) && (MULTIPLICITY != '0);

  // Window shift and occupancy tracking; a firing decision clears both and wins.
  always_comb begin
    fire     = tick && (occ_q > OCCUPANCY) && (hold_q == '0);
    window_d = window_q;
    occ_d    = occ_q;
    hold_d   = hold_q;
    count_d  = count_q;
    trig_d   = 1'b0;
    if (tick) begin
      if (fire) begin
        window_d = '0;
        occ_d    = '0;
        hold_d   = HOLDOFF;
        count_d  = count_q + 32'd1;
        trig_d   = 1'b1;
      end else begin
        window_d = {window_q[WIDTH-2:0], sb_q};
        if (sb_q && !window_q[WIDTH-1] && (occ_q != OCC_W'(WIDTH))) begin
          occ_d = occ_q + 1'b1;
        end else if (!sb_q && window_q[WIDTH-1] && (occ_q != '0)) begin
          occ_d = occ_q - 1'b1;
        end
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_q  <= '0;
      adc_q    <= '0;
      thres_q  <= '0;
      pmt_q    <= '0;
      sum_q    <= '0;
      sb_q     <= 1'b0;
      debug_q  <= 1'b0;
      window_q <= '0;
      occ_q    <= '0;
      hold_q   <= '0;
      trig_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      phase_q  <= phase_d;
      debug_q  <= sb_d;
      window_q <= window_d;
      occ_q    <= occ_d;
      hold_q   <= hold_d;
      trig_q   <= trig_d;
      count_q  <= count_d;
      if (tick) begin
        adc_q   <= ADC;
        thres_q <= THRES;
        pmt_q   <= pmt_d;
        sum_q   <= sum_d;
        sb_q    <= sb_d;
      end
    end
  end

`ifdef TOT_PEAK_OCC_EN
  logic [OCC_W-1:0] peak_q;

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      peak_q <= '0;
    end else if (PEAK_CLR) begin
      peak_q <= occ_q;
    end else if (tick && (occ_q > peak_q)) begin
      peak_q <= occ_q;
    end
  end

  assign PEAK_OCC = peak_q;
`endif

  assign TRIG       = trig_q;
  assign TRIG_COUNT = count_q;
  assign OCC_NOW    = occ_q;
  assign DEBUG      = debug_q;

endmodule
